// File: rtl/uart_rx_ctrl.sv
// UART receive controller: live config with between-frame updates, received-byte FIFO, overflow flag.
// Latency: pushed byte visible on m_valid/m_data 1 cycle after rx_data_valid; config applies 1 cycle after cfg_pending.
// Backpressure: m_valid/m_ready handshake; a byte arriving on a full FIFO with no pop is dropped and sets overflow.
// Optional: define UART_RX_ERR_CNT_EN to add the saturating err_cnt frame-error counter port.
module uart_rx_ctrl #(
  parameter int          DATA_W       = 8,
  parameter int          DEPTH        = 4,
  parameter logic [1:0]  PRESCALE_RST = 2'b01,
  parameter logic        PAR_EN_RST   = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_wr,
  input  logic [1:0]               cfg_prescale,
  input  logic                     cfg_par_en,
  output logic                     cfg_pending,
  input  logic                     rx_busy,
  output logic [1:0]               rx_prescale,
  output logic                     rx_par_en,
  input  logic [DATA_W-1:0]        rx_data,
  input  logic                     rx_data_valid,
  input  logic                     rx_frame_err,
  output logic [DATA_W-1:0]        m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
`ifdef UART_RX_ERR_CNT_EN
  output logic [7:0]               err_cnt,
`endif
  input  logic                     ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Config shadow / live registers
  logic [1:0] shadow_prescale;
  logic       shadow_par_en;
  logic       apply;

  // Live settings may only move when the receiver is idle and not handing
  // over a byte, so a frame never sees a mix of old and new settings.
  assign apply = cfg_pending && !rx_busy && !rx_data_valid;

  // Shadow capture, pending flag and live update
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_prescale <= PRESCALE_RST;
      shadow_par_en   <= PAR_EN_RST;
      cfg_pending     <= 1'b0;
      rx_prescale     <= PRESCALE_RST;
      rx_par_en       <= PAR_EN_RST;
    end else begin
      if (apply) begin
        rx_prescale <= shadow_prescale;
        rx_par_en   <= shadow_par_en;
      end
      // A write on the apply edge lands in the shadow and keeps pending set;
      // the live side takes the value that was in the shadow before it.
      if (cfg_wr) begin
        shadow_prescale <= cfg_prescale;
        shadow_par_en   <= cfg_par_en;
        cfg_pending     <= 1'b1;
      end else if (apply) begin
        cfg_pending <= 1'b0;
      end
    end
  end

  // FIFO pointers carry an extra wrap bit to tell full from empty
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              ovf_set;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = !empty && m_ready;
  assign push    = rx_data_valid && (!full || pop);
  assign ovf_set = rx_data_valid && full && !pop;

  assign m_valid    = !empty;
  assign m_data     = mem[rd_ptr[AW-1:0]];
  assign fifo_level = wr_ptr - rd_ptr;

  // Pointer advance; push and pop may both happen on one edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage write; on full-with-pop the slot being vacated is reused
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= rx_data;
  end

  // Sticky overflow; a new drop outranks a clear in the same cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          overflow <= 1'b0;
    else if (ovf_set)  overflow <= 1'b1;
    else if (ovf_clr)  overflow <= 1'b0;
  end

`ifdef UART_RX_ERR_CNT_EN
  // Saturating frame-error counter; an error outranks a clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt <= 8'd0;
    end else if (rx_frame_err) begin
      if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end else if (ovf_clr) begin
      err_cnt <= 8'd0;
    end
  end
`else
  // Frame errors need no action when the counter is left out
  logic unused_frame_err;
  assign unused_frame_err = rx_frame_err;
`endif

endmodule
